// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    // Load-use hazard: EX load writes a non-x0 register that ID reads
    function automatic logic load_use(
        input logic                 ex_memread,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic                 use_rs1,
        input logic [REG_IDX_W-1:0] rs1,
        input logic                 use_rs2,
        input logic [REG_IDX_W-1:0] rs2
    );
        logic hit_s;
        hit_s = (use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd));
        return ex_memread && (ex_rd != REG_X0) && hit_s;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-side signal bundle of the fetch controller.
interface fetch_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]                          i_inc_pc;
    logic                                 i_imem_ready;
    logic [fetch_ctrl_pkg::REG_IDX_W-1:0] i_id_rs1;
    logic [fetch_ctrl_pkg::REG_IDX_W-1:0] i_id_rs2;
    logic                                 i_id_use_rs1;
    logic                                 i_id_use_rs2;
    logic                                 i_id_halt;
    logic                                 i_ex_memread;
    logic [fetch_ctrl_pkg::REG_IDX_W-1:0] i_ex_rd;
    logic                                 i_ex_redirect;
    logic [31:0]                          i_ex_target;
    logic [31:0]                          o_next_pc;
    logic                                 o_pc_hold;
    logic                                 o_ifid_hold;
    logic                                 o_ifid_flush;
    logic                                 o_idex_flush;
    logic                                 o_halted;
    logic [CNT_W-1:0]                     o_stall_cnt;
    logic [CNT_W-1:0]                     o_redirect_cnt;

    // Pipeline side: drives status, receives sequencing controls
    modport master (
        output i_inc_pc, i_imem_ready, i_id_rs1, i_id_rs2, i_id_use_rs1,
               i_id_use_rs2, i_id_halt, i_ex_memread, i_ex_rd,
               i_ex_redirect, i_ex_target,
        input  o_next_pc, o_pc_hold, o_ifid_hold, o_ifid_flush,
               o_idex_flush, o_halted, o_stall_cnt, o_redirect_cnt
    );

    // Controller side
    modport slave (
        input  i_inc_pc, i_imem_ready, i_id_rs1, i_id_rs2, i_id_use_rs1,
               i_id_use_rs2, i_id_halt, i_ex_memread, i_ex_rd,
               i_ex_redirect, i_ex_target,
        output o_next_pc, o_pc_hold, o_ifid_hold, o_ifid_flush,
               o_idex_flush, o_halted, o_stall_cnt, o_redirect_cnt
    );
endinterface

// File: rtl/fetch_ctrl_chk.sv
// Run-time checks of controller invariants.
module fetch_ctrl_chk
    import fetch_ctrl_pkg::*;
(
    input logic   i_clk,
    input logic   i_rst,
    input state_e state,
    input logic   i_ex_redirect,
    input logic   o_ifid_hold,
    input logic   o_ifid_flush
);
    // A redirect while PEND can only come from a bubble; hold and flush are exclusive
    always @(posedge i_clk) begin
        if (i_rst) begin
            assert (!((state == ST_PEND) && i_ex_redirect))
                else $error("fetch_ctrl: redirect seen while redirect pending");
            assert (!(o_ifid_hold && o_ifid_flush))
                else $error("fetch_ctrl: IF/ID hold and flush both asserted");
        end
    end
endmodule

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: next-PC select, hazard stalls,
// redirect flushes, imem wait absorption, sticky halt, perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         i_clk,
    input logic         i_rst,
    fetch_ctrl_if.slave bus
);
    state_e      state_q;
    state_e      state_d;
    logic [31:0] saved_target_q;
    logic [31:0] saved_target_d;

    logic        luse_s;
    logic [31:0] next_pc_s;
    logic        pc_hold_s;
    logic        ifid_hold_s;
    logic        ifid_flush_s;
    logic        idex_flush_s;
    logic        halted_s;
    logic        stall_inc_s;
    logic        redirect_inc_s;

    assign luse_s = load_use(bus.i_ex_memread, bus.i_ex_rd,
                             bus.i_id_use_rs1, bus.i_id_rs1,
                             bus.i_id_use_rs2, bus.i_id_rs2);

    // Next state and zero-latency control outputs
    always_comb begin
        state_d        = state_q;
        saved_target_d = saved_target_q;
        next_pc_s      = bus.i_inc_pc;
        pc_hold_s      = 1'b0;
        ifid_hold_s    = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_flush_s   = 1'b0;
        halted_s       = 1'b0;
        stall_inc_s    = 1'b0;
        redirect_inc_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.i_ex_redirect && bus.i_imem_ready) begin
                    // Redirect wins over luse/halt: the ID instruction is wrong-path
                    next_pc_s      = bus.i_ex_target;
                    ifid_flush_s   = 1'b1;
                    idex_flush_s   = 1'b1;
                    redirect_inc_s = 1'b1;
                end else if (bus.i_ex_redirect) begin
                    saved_target_d = bus.i_ex_target;
                    pc_hold_s      = 1'b1;
                    ifid_flush_s   = 1'b1;
                    idex_flush_s   = 1'b1;
                    redirect_inc_s = 1'b1;
                    state_d        = ST_PEND;
                end else if (bus.i_id_halt) begin
                    pc_hold_s      = 1'b1;
                    ifid_flush_s   = 1'b1;
                    state_d        = ST_HALT;
                end else if (luse_s) begin
                    pc_hold_s      = 1'b1;
                    ifid_hold_s    = 1'b1;
                    idex_flush_s   = 1'b1;
                    stall_inc_s    = 1'b1;
                end else if (!bus.i_imem_ready) begin
                    pc_hold_s      = 1'b1;
                    ifid_flush_s   = 1'b1;
                    stall_inc_s    = 1'b1;
                end else begin
                    next_pc_s      = bus.i_inc_pc;
                end
            end
            ST_PEND: begin
                ifid_flush_s = 1'b1;
                if (bus.i_ex_redirect) begin
                    saved_target_d = bus.i_ex_target;
                end else begin
                    saved_target_d = saved_target_q;
                end
                if (bus.i_imem_ready) begin
                    next_pc_s = saved_target_q;
                    state_d   = ST_RUN;
                end else begin
                    pc_hold_s   = 1'b1;
                    stall_inc_s = 1'b1;
                end
            end
            ST_HALT: begin
                halted_s     = 1'b1;
                pc_hold_s    = 1'b1;
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
            end
            default: begin
                // Illegal encoding: freeze fetch and recover to RUN
                pc_hold_s    = 1'b1;
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
                state_d      = ST_RUN;
            end
        endcase
    end

    // State and saved redirect target registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= ST_RUN;
            saved_target_q <= RESET_PC;
        end else begin
            state_q        <= state_d;
            saved_target_q <= saved_target_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (stall_inc_s),
        .count (bus.o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (redirect_inc_s),
        .count (bus.o_redirect_cnt)
    );

    fetch_ctrl_chk u_chk (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .state         (state_q),
        .i_ex_redirect (bus.i_ex_redirect),
        .o_ifid_hold   (ifid_hold_s),
        .o_ifid_flush  (ifid_flush_s)
    );

    assign bus.o_next_pc    = next_pc_s;
    assign bus.o_pc_hold    = pc_hold_s;
    assign bus.o_ifid_hold  = ifid_hold_s;
    assign bus.o_ifid_flush = ifid_flush_s;
    assign bus.o_idex_flush = idex_flush_s;
    assign bus.o_halted     = halted_s;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural model plus directed checks.
module tb_fetch_ctrl;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_ctrl #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: mode flags, saved target and plain integer counters
    bit          m_pend, m_halt, n_pend, n_halt;
    logic [31:0] m_tgt, n_tgt;
    int          m_stall, m_redir, n_stall, n_redir;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Model: expected outputs from the rules, compared every cycle out of reset
    always @(negedge clk) begin : model_cmp
        logic [31:0] e_pc;
        bit e_hold, e_ifh, e_iff, e_idf, e_halted, luse;
        e_pc = bus.i_inc_pc;
        e_hold = 0; e_ifh = 0; e_iff = 0; e_idf = 0; e_halted = 0;
        n_pend = m_pend; n_halt = m_halt; n_tgt = m_tgt;
        n_stall = m_stall; n_redir = m_redir;
        luse = bus.i_ex_memread && (bus.i_ex_rd != 5'd0) &&
               ((bus.i_id_use_rs1 && bus.i_id_rs1 == bus.i_ex_rd) ||
                (bus.i_id_use_rs2 && bus.i_id_rs2 == bus.i_ex_rd));
        if (!rst_n) begin
            n_pend = 0; n_halt = 0; n_tgt = RESET_PC; n_stall = 0; n_redir = 0;
        end else begin
            if (m_halt) begin
                e_halted = 1; e_hold = 1; e_iff = 1; e_idf = 1;
            end else if (m_pend) begin
                e_iff = 1;
                if (bus.i_ex_redirect) n_tgt = bus.i_ex_target;
                if (bus.i_imem_ready) begin
                    e_pc = m_tgt; n_pend = 0;
                end else begin
                    e_hold = 1; n_stall = sat_inc(m_stall);
                end
            end else if (bus.i_ex_redirect) begin
                e_iff = 1; e_idf = 1; n_redir = sat_inc(m_redir);
                if (bus.i_imem_ready) e_pc = bus.i_ex_target;
                else begin e_hold = 1; n_pend = 1; n_tgt = bus.i_ex_target; end
            end else if (bus.i_id_halt) begin
                e_hold = 1; e_iff = 1; n_halt = 1;
            end else if (luse) begin
                e_hold = 1; e_ifh = 1; e_idf = 1; n_stall = sat_inc(m_stall);
            end else if (!bus.i_imem_ready) begin
                e_hold = 1; e_iff = 1; n_stall = sat_inc(m_stall);
            end
            if (!e_hold) chk("next_pc", bus.o_next_pc, e_pc);
            chk("pc_hold",    {31'd0, bus.o_pc_hold},    {31'd0, e_hold});
            chk("ifid_hold",  {31'd0, bus.o_ifid_hold},  {31'd0, e_ifh});
            chk("ifid_flush", {31'd0, bus.o_ifid_flush}, {31'd0, e_iff});
            chk("idex_flush", {31'd0, bus.o_idex_flush}, {31'd0, e_idf});
            chk("halted",     {31'd0, bus.o_halted},     {31'd0, e_halted});
            chk("stall_cnt",  {28'd0, bus.o_stall_cnt},    m_stall);
            chk("redir_cnt",  {28'd0, bus.o_redirect_cnt}, m_redir);
        end
    end

    // Model state update on the clock, asynchronous reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 0; m_halt <= 0; m_tgt <= RESET_PC; m_stall <= 0; m_redir <= 0;
        end else begin
            m_pend <= n_pend; m_halt <= n_halt; m_tgt <= n_tgt;
            m_stall <= n_stall; m_redir <= n_redir;
        end
    end

    task automatic idle();
        bus.i_imem_ready = 1'b1; bus.i_id_rs1 = 5'd0; bus.i_id_rs2 = 5'd0;
        bus.i_id_use_rs1 = 1'b0; bus.i_id_use_rs2 = 1'b0; bus.i_id_halt = 1'b0;
        bus.i_ex_memread = 1'b0; bus.i_ex_rd = 5'd0; bus.i_ex_redirect = 1'b0;
        bus.i_ex_target = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i_inc_pc = 32'h4;
        idle();
        #12 rst_n = 1'b1;
        // Reset state, plain RUN
        @(negedge clk);
        chk("lit_reset_pc",    bus.o_next_pc, 32'h4);
        chk("lit_reset_stall", {28'd0, bus.o_stall_cnt}, 32'd0);
        chk("lit_reset_ctl",   {28'd0, bus.o_pc_hold, bus.o_ifid_hold,
                                bus.o_ifid_flush, bus.o_idex_flush}, 32'd0);
        next_cycle();
        // Load-use on rs1
        bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd5;
        bus.i_id_rs1 = 5'd5; bus.i_id_use_rs1 = 1'b1;
        @(negedge clk);
        chk("lit_luse_ctl", {29'd0, bus.o_pc_hold, bus.o_ifid_hold, bus.o_idex_flush}, 32'd7);
        next_cycle();
        // Same with rd=x0: no stall
        bus.i_ex_rd = 5'd0; bus.i_id_rs1 = 5'd0;
        @(negedge clk);
        chk("lit_x0_hold",  {31'd0, bus.o_pc_hold}, 32'd0);
        chk("lit_x0_stall", {28'd0, bus.o_stall_cnt}, 32'd1);
        next_cycle();
        // Redirect overriding a load-use
        bus.i_ex_rd = 5'd5; bus.i_id_rs1 = 5'd5;
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h100;
        @(negedge clk);
        chk("lit_redir_pc",   bus.o_next_pc, 32'h100);
        chk("lit_redir_hold", {31'd0, bus.o_pc_hold}, 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("lit_redir_cnt",  {28'd0, bus.o_redirect_cnt}, 32'd1);
        chk("lit_redir_stall", {28'd0, bus.o_stall_cnt}, 32'd1);
        next_cycle();
        // Redirect while imem stalls: redirect cycle plus 3 PEND wait cycles
        bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h200; bus.i_imem_ready = 1'b0;
        next_cycle();
        bus.i_ex_redirect = 1'b0; bus.i_ex_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_pend_hold", {31'd0, bus.o_pc_hold}, 32'd1);
            next_cycle();
        end
        bus.i_imem_ready = 1'b1;
        @(negedge clk);
        chk("lit_pend_pc",    bus.o_next_pc, 32'h200);
        chk("lit_pend_stall", {28'd0, bus.o_stall_cnt}, 32'd4);
        next_cycle();
        @(negedge clk);
        chk("lit_run_pc", bus.o_next_pc, 32'h4);
        chk("lit_pend_redir", {28'd0, bus.o_redirect_cnt}, 32'd2);
        next_cycle();
        // Halt, then redirects are ignored
        bus.i_id_halt = 1'b1;
        next_cycle();
        bus.i_id_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_ex_redirect = 1'b1; bus.i_ex_target = 32'h300;
            bus.i_imem_ready = i[0];
            @(negedge clk);
            chk("lit_halted", {30'd0, bus.o_halted, bus.o_pc_hold}, 32'd3);
            next_cycle();
        end
        idle();
        // Asynchronous reset mid-cycle leaves HALT immediately
        #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_halted", {31'd0, bus.o_halted}, 32'd0);
        chk("lit_rst_hold",   {31'd0, bus.o_pc_hold}, 32'd0);
        chk("lit_rst_redir",  {28'd0, bus.o_redirect_cnt}, 32'd0);
        #5 rst_n = 1'b1;
        next_cycle();
        // Saturation: 2 imem waits then 18 load-use stalls
        bus.i_imem_ready = 1'b0;
        next_cycle();
        next_cycle();
        bus.i_imem_ready = 1'b1; bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd9;
        bus.i_id_rs2 = 5'd9; bus.i_id_use_rs2 = 1'b1;
        for (int i = 0; i < 18; i++) next_cycle();
        idle();
        @(negedge clk);
        chk("lit_sat_stall", {28'd0, bus.o_stall_cnt}, 32'hF);
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
